dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between the pipeline MEM stage (CPU) and an external DMA/loader requester.
- Sits between the EX/MEM register outputs and the data memory.
- CPU has default priority and zero added latency.
- DMA is served opportunistically in CPU-idle cycles, with a starvation counter that forces a bounded DMA burst and stalls the pipeline.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the memory.
- DATA_WIDTH, 32, data width.
- MAX_WAIT, 8, consecutive denied DMA-request cycles before a forced DMA burst (>=1).
- BURST_MAX, 4, maximum beats in one forced DMA burst (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_mem_read  in  1  MEM-stage load request.
- cpu_mem_write  in  1  MEM-stage store request.
- cpu_addr  in  ADDR_WIDTH  MEM-stage address (ALU result).
- cpu_wdata  in  DATA_WIDTH  MEM-stage store data.
- cpu_rdata  out  DATA_WIDTH  load data to the MEM/WB register.
- cpu_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM; bubbles MEM/WB.
- dma_req  in  1  DMA beat request; held with its address and data until granted.
- dma_we  in  1  1 = write beat, 0 = read beat.
- dma_addr  in  ADDR_WIDTH  DMA address.
- dma_wdata  in  DATA_WIDTH  DMA write data.
- dma_last  in  1  marks the final beat of a DMA transfer.
- dma_gnt  out  1  beat accepted this cycle.
- dma_rvalid  out  1  registered read-data valid.
- dma_rdata  out  DATA_WIDTH  registered read data.
- mem_addr  out  ADDR_WIDTH  to data memory.
- mem_wdata  out  DATA_WIDTH  to data memory.
- mem_write_en  out  1  to data memory.
- mem_read_en  out  1  to data memory.
- mem_rdata  in  DATA_WIDTH  combinational read data from data memory.

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high.
- Definitions: cpu_req = cpu_mem_read | cpu_mem_write. If both are high, the write wins and mem_read_en = 0.
- Reset values: state S_CPU; wait_cnt = 0; beat_cnt = 0; dma_rvalid = 0; dma_rdata = 0. Combinational outputs follow S_CPU with no requests: all memory enables 0, cpu_stall = 0, dma_gnt = 0.
- State S_CPU:
  - CPU owns the memory. Memory outputs mux the cpu_* signals combinationally. cpu_stall = 0.
  - dma_gnt = dma_req & ~cpu_req (opportunistic beat, muxed to memory the same cycle).
  - wait_cnt increments when dma_req & cpu_req; clears when dma_gnt or ~dma_req; saturates at MAX_WAIT.
  - Go to S_DMA when dma_req & cpu_req & (wait_cnt == MAX_WAIT-1); clear beat_cnt.
- State S_DMA:
  - DMA owns the memory. dma_gnt = dma_req. cpu_stall = cpu_req. CPU enables are not driven to memory.
  - beat_cnt increments per granted beat.
  - Return to S_CPU (clearing wait_cnt) after a granted beat with dma_last, or when beat_cnt reaches BURST_MAX-1 on a granted beat, or when dma_req is low.
- Read return: for a granted DMA read beat, dma_rdata <= mem_rdata and dma_rvalid <= 1 at the next edge (latency 1). Otherwise dma_rvalid <= 0.
- CPU read data: cpu_rdata = mem_rdata combinationally when the CPU owns the cycle; 0 otherwise.
- Simultaneous dma_req and cpu_req in S_CPU with wait_cnt < MAX_WAIT-1: CPU served, DMA denied, no stall.
- Reset mid-burst: returns to S_CPU next edge; a pending dma_rvalid is dropped; the pipeline is unstalled.
- cpu_stall depends only on the registered state and cpu_req, so there is no combinational loop through the pipeline.

Optional Feature:
DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_conflicts (32-bit, +1 per cycle with dma_req & cpu_req), stat_stall_cycles (32-bit, +1 per cycle cpu_stall = 1) and stat_forced (16-bit, +1 per S_CPU->S_DMA transition). All counters wrap, are cleared by reset, and are read-only.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- CPU-only traffic: store 0xDEADBEEF to 0x10, then load 0x10 -> mem_write_en for 1 cycle, cpu_rdata = 0xDEADBEEF the same cycle, cpu_stall never 1.
- DMA into idle CPU: dma write of 0x0000_00AA to 0x20 with no cpu_req -> dma_gnt the same cycle. DMA read of 0x20 -> dma_rvalid 1 cycle later with dma_rdata = 0xAA.
- Starvation: cpu_req held high, dma_req high, MAX_WAIT = 8 -> dma_gnt 0 for 8 cycles; S_DMA entered on cycle 9; cpu_stall = 1 while DMA beats are granted.
- Burst cap: in forced mode, dma_req held high with no dma_last, BURST_MAX = 4 -> exactly 4 grants, then return to S_CPU, cpu_stall drops, wait_cnt = 0.
- dma_last on beat 2 of a forced burst -> exit after beat 2; the CPU's pending load completes the next cycle.
- Reset asserted during beat 2 of a forced burst -> next cycle: S_CPU, cpu_stall = 0, dma_rvalid = 0, wait_cnt = 0, beat_cnt = 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU MEM-stage, DMA and data-memory signals shared by the arbiter and its environment
interface dmem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  cpu_mem_read;
   logic                  cpu_mem_write;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic                  cpu_stall;
   logic                  dma_req;
   logic                  dma_we;
   logic [ADDR_WIDTH-1:0] dma_addr;
   logic [DATA_WIDTH-1:0] dma_wdata;
   logic                  dma_last;
   logic                  dma_gnt;
   logic                  dma_rvalid;
   logic [DATA_WIDTH-1:0] dma_rdata;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_write_en;
   logic                  mem_read_en;
   logic [DATA_WIDTH-1:0] mem_rdata;
   modport slave (
      input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata, dma_last,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_addr, mem_wdata, mem_write_en, mem_read_en,
      input  mem_rdata
   );
   modport master (
      output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata, dma_last,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_addr, mem_wdata, mem_write_en, mem_read_en,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data memory between the CPU MEM stage and a DMA requester; DMEM_ARB_STATS_EN adds statistics counters
module dmem_arbiter #(
   parameter int MAX_WAIT  = 8,
   parameter int BURST_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]   stat_conflicts,
   output logic [31:0]   stat_stall_cycles,
   output logic [15:0]   stat_forced
`endif
);
   localparam logic [0:0] S_CPU = 1'b0;
   localparam logic [0:0] S_DMA = 1'b1;
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
   localparam logic [WW-1:0] WAIT_SAT  = WW'(MAX_WAIT);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);
   logic [0:0]    state;
   logic [WW-1:0] wait_cnt;
   logic [BW-1:0] beat_cnt;
   logic          cpu_req;
   logic          conflict;
   logic          gnt;
   logic          cpu_own;
   logic          force_dma;
   logic          burst_end;
   // ownership decode and memory mux; cpu_stall only sees registered state and cpu_req
   always_comb begin
      cpu_req          = bus.cpu_mem_read | bus.cpu_mem_write;
      conflict         = bus.dma_req & cpu_req;
      gnt              = (state == S_CPU) ? bus.dma_req & ~cpu_req : bus.dma_req;
      cpu_own          = (state == S_CPU) & cpu_req;
      force_dma        = (state == S_CPU) & conflict & (wait_cnt == WAIT_LAST);
      burst_end        = ~bus.dma_req | bus.dma_last | (beat_cnt == BEAT_LAST);
      bus.dma_gnt      = gnt;
      bus.cpu_stall    = (state == S_DMA) & cpu_req;
      bus.mem_addr     = gnt ? bus.dma_addr : bus.cpu_addr;
      bus.mem_wdata    = gnt ? bus.dma_wdata : bus.cpu_wdata;
      bus.mem_write_en = cpu_own ? bus.cpu_mem_write : gnt & bus.dma_we;
      bus.mem_read_en  = cpu_own ? bus.cpu_mem_read & ~bus.cpu_mem_write : gnt & ~bus.dma_we;
      bus.cpu_rdata    = cpu_own ? bus.mem_rdata : '0;
   end
   // ownership state, starvation counter and forced-burst beat counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_CPU;
         wait_cnt <= '0;
         beat_cnt <= '0;
      end else if (state == S_CPU) begin
         state    <= force_dma ? S_DMA : S_CPU;
         wait_cnt <= ~conflict ? '0 : (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + 1'b1;
         beat_cnt <= '0;
      end else begin
         state    <= burst_end ? S_CPU : S_DMA;
         wait_cnt <= burst_end ? '0 : wait_cnt;
         beat_cnt <= gnt ? beat_cnt + 1'b1 : beat_cnt;
      end
   end
   // DMA read data returns one cycle after the granted read beat
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.dma_rvalid <= 1'b0;
         bus.dma_rdata  <= '0;
      end else begin
         bus.dma_rvalid <= gnt & ~bus.dma_we;
         if (gnt & ~bus.dma_we) bus.dma_rdata <= bus.mem_rdata;
      end
   end
`ifdef DMEM_ARB_STATS_EN
   // wrapping contention, stall and forced-burst counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_conflicts    <= '0;
         stat_stall_cycles <= '0;
         stat_forced       <= '0;
      end else begin
         stat_conflicts    <= stat_conflicts + {31'd0, conflict};
         stat_stall_cycles <= stat_stall_cycles + {31'd0, bus.cpu_stall};
         stat_forced       <= stat_forced + {15'd0, force_dma};
      end
   end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario tasks with a read-data scoreboard against a behavioural data memory
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic reset;
   int total = 0;
   int bad = 0;
   logic [31:0] sb[$];
   logic [31:0] mem [0:255];
   always #5 clk = ~clk;
   dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
`ifdef DMEM_ARB_STATS_EN
   logic [31:0] stat_conflicts;
   logic [31:0] stat_stall_cycles;
   logic [15:0] stat_forced;
`endif
   dmem_arbiter #(.MAX_WAIT(8), .BURST_MAX(4)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_conflicts(stat_conflicts),
      .stat_stall_cycles(stat_stall_cycles),
      .stat_forced(stat_forced)
`endif
   );
   assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
   // single-port data memory model with synchronous write
   always @(posedge clk) if (bus.mem_write_en) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
   task automatic next;
      @(posedge clk);
      #1;
   endtask
   task automatic idle;
      bus.cpu_mem_read = 0; bus.cpu_mem_write = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_last = 0;
   endtask
   task automatic test_reset;
      reset = 1'b1;
      idle();
      next();
      next();
      #3;
      total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", bus.dma_rvalid); end
      total++; if (bus.dma_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.dma_rdata); end
      total++; if ({bus.mem_write_en, bus.mem_read_en} !== 2'b00) begin bad++; $display("FAIL reset_mem_en got=%b exp=00", {bus.mem_write_en, bus.mem_read_en}); end
      total++; if ({bus.cpu_stall, bus.dma_gnt} !== 2'b00) begin bad++; $display("FAIL reset_stall_gnt got=%b exp=00", {bus.cpu_stall, bus.dma_gnt}); end
      total++; if (dut.state !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", dut.state); end
      reset = 1'b0;
      next();
   endtask
   task automatic test_cpu_only;
      bus.cpu_mem_write = 1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
      #3;
      total++; if (bus.mem_write_en !== 1'b1) begin bad++; $display("FAIL cpu_store_we got=%b exp=1", bus.mem_write_en); end
      total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL cpu_store_stall got=%b exp=0", bus.cpu_stall); end
      next();
      bus.cpu_mem_write = 0; bus.cpu_mem_read = 1;
      #3;
      total++; if (bus.mem_write_en !== 1'b0) begin bad++; $display("FAIL cpu_load_we got=%b exp=0", bus.mem_write_en); end
      total++; if (bus.mem_read_en !== 1'b1) begin bad++; $display("FAIL cpu_load_re got=%b exp=1", bus.mem_read_en); end
      total++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_load_data got=%h exp=deadbeef", bus.cpu_rdata); end
      total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL cpu_load_stall got=%b exp=0", bus.cpu_stall); end
      next();
      bus.cpu_mem_write = 1; bus.cpu_addr = 32'h14; bus.cpu_wdata = 32'h1234;
      #3;
      total++; if ({bus.mem_write_en, bus.mem_read_en} !== 2'b10) begin bad++; $display("FAIL cpu_rw_both got=%b exp=10", {bus.mem_write_en, bus.mem_read_en}); end
      next();
      idle();
   endtask
   task automatic test_dma_idle;
      bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h20; bus.dma_wdata = 32'hAA; bus.dma_last = 1;
      #3;
      total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL dma_wr_gnt got=%b exp=1", bus.dma_gnt); end
      total++; if (bus.mem_write_en !== 1'b1) begin bad++; $display("FAIL dma_wr_we got=%b exp=1", bus.mem_write_en); end
      total++; if (bus.mem_addr !== 32'h20) begin bad++; $display("FAIL dma_wr_addr got=%h exp=20", bus.mem_addr); end
      next();
      bus.dma_we = 0;
      #3;
      total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL dma_rd_gnt got=%b exp=1", bus.dma_gnt); end
      total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL dma_wr_rvalid got=%b exp=0", bus.dma_rvalid); end
      sb.push_back(32'hAA);
      next();
      idle();
      for (int c = 0; c < 2; c++) begin
         #3;
         if (bus.dma_rvalid) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL dma_idle_rvalid spurious c=%0d got=1 exp=0", c); end
            else begin logic [31:0] e; e = sb.pop_front(); if (bus.dma_rdata !== e) begin bad++; $display("FAIL dma_idle_rdata got=%h exp=%h", bus.dma_rdata, e); end end
         end
         next();
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL dma_idle_pending got=%0d exp=0", sb.size()); sb.delete(); end
   endtask
   task automatic test_starvation_burst;
      for (int c = 1; c <= 23; c++) begin
         logic g, s;
         g = (c >= 9 && c <= 12) || c == 21;
         s = g || c == 22;
         bus.cpu_mem_read = 1; bus.cpu_addr = 32'h10;
         bus.dma_req = (c <= 21); bus.dma_we = 0; bus.dma_addr = 32'h20; bus.dma_last = 0;
         #3;
         total++; if (bus.dma_gnt !== g) begin bad++; $display("FAIL starve_gnt c=%0d got=%b exp=%b", c, bus.dma_gnt, g); end
         total++; if (bus.cpu_stall !== s) begin bad++; $display("FAIL starve_stall c=%0d got=%b exp=%b", c, bus.cpu_stall, s); end
         total++; if (bus.cpu_rdata !== (s ? 32'h0 : 32'hDEADBEEF)) begin bad++; $display("FAIL starve_cpu_rdata c=%0d got=%h exp=%h", c, bus.cpu_rdata, s ? 32'h0 : 32'hDEADBEEF); end
         if (bus.dma_rvalid) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL starve_rvalid spurious c=%0d got=1 exp=0", c); end
            else begin logic [31:0] e; e = sb.pop_front(); if (bus.dma_rdata !== e) begin bad++; $display("FAIL starve_rdata c=%0d got=%h exp=%h", c, bus.dma_rdata, e); end end
         end
         if (c == 13) begin
            total++; if (dut.wait_cnt !== '0) begin bad++; $display("FAIL burst_wait_clear got=%0d exp=0", dut.wait_cnt); end
         end
         if (g) sb.push_back(32'hAA);
         next();
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL starve_pending got=%0d exp=0", sb.size()); sb.delete(); end
   endtask
   task automatic test_dma_last;
      for (int c = 1; c <= 12; c++) begin
         logic g;
         g = (c == 9 || c == 10);
         bus.cpu_mem_read = 1; bus.cpu_addr = 32'h10;
         bus.dma_req = (c <= 11); bus.dma_we = 0; bus.dma_addr = (c == 10) ? 32'h10 : 32'h20; bus.dma_last = (c == 10);
         #3;
         total++; if (bus.dma_gnt !== g) begin bad++; $display("FAIL last_gnt c=%0d got=%b exp=%b", c, bus.dma_gnt, g); end
         total++; if (bus.cpu_stall !== g) begin bad++; $display("FAIL last_stall c=%0d got=%b exp=%b", c, bus.cpu_stall, g); end
         if (c == 11) begin
            total++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL last_cpu_load got=%h exp=deadbeef", bus.cpu_rdata); end
         end
         if (bus.dma_rvalid) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL last_rvalid spurious c=%0d got=1 exp=0", c); end
            else begin logic [31:0] e; e = sb.pop_front(); if (bus.dma_rdata !== e) begin bad++; $display("FAIL last_rdata c=%0d got=%h exp=%h", c, bus.dma_rdata, e); end end
         end
         if (g) sb.push_back((c == 10) ? 32'hDEADBEEF : 32'hAA);
         next();
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL last_pending got=%0d exp=0", sb.size()); sb.delete(); end
   endtask
   task automatic test_reset_mid_burst;
      for (int c = 1; c <= 10; c++) begin
         bus.cpu_mem_read = 1; bus.cpu_addr = 32'h10;
         bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h20; bus.dma_last = 0;
         reset = (c == 10);
         #3;
         if (bus.dma_rvalid) begin
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL rst_rvalid spurious c=%0d got=1 exp=0", c); end
            else begin logic [31:0] e; e = sb.pop_front(); if (bus.dma_rdata !== e) begin bad++; $display("FAIL rst_rdata c=%0d got=%h exp=%h", c, bus.dma_rdata, e); end end
         end
         if (c == 10) begin
            total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL rst_beat2_gnt got=%b exp=1", bus.dma_gnt); end
         end
         if (c == 9) sb.push_back(32'hAA);
         next();
      end
      reset = 0;
      #3;
      total++; if (dut.state !== 1'b0) begin bad++; $display("FAIL rst_mid_state got=%b exp=0", dut.state); end
      total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b exp=0", bus.cpu_stall); end
      total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL rst_mid_rvalid got=%b exp=0", bus.dma_rvalid); end
      total++; if (dut.wait_cnt !== '0) begin bad++; $display("FAIL rst_mid_wait got=%0d exp=0", dut.wait_cnt); end
      total++; if (dut.beat_cnt !== '0) begin bad++; $display("FAIL rst_mid_beat got=%0d exp=0", dut.beat_cnt); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL rst_mid_pending got=%0d exp=0", sb.size()); sb.delete(); end
      next();
      idle();
   endtask
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      test_reset();
      test_cpu_only();
      test_dma_idle();
      test_starvation_burst();
      test_dma_last();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
